rom_arbiter: RTL and testbench

Shares the single combinational read port of the instruction/constant ROM between two requesters: the fetch stage (IF) and the load unit (LD, constant-pool and `.rodata` reads). It sits between the core pipeline and the ROM instance.
- Per cycle it grants at most one request, using round-robin on conflict.
- It drives the ROM address, registers the returned word, and presents a one-cycle-later response with error flagging.
- It counts contention cycles for performance analysis.

---
 rtl/rom_arbiter_pkg.sv | 20 ++
 rtl/rom_arbiter.sv | 105 ++++++++++
 tb/tb_rom_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM read-port arbiter: port ids, alignment mask,
// default widths and the address range/alignment check.
package rom_arbiter_pkg;

  localparam int unsigned MXLEN       = 32;
  localparam int unsigned ROM_COL_MAX = 256;

  localparam logic [1:0] ROM_ADDR_ALIGN_MASK = 2'b11;

  typedef enum logic {
    RomPortIf = 1'b0,
    RomPortLd = 1'b1
  } rom_port_e;

  // True when the byte address is misaligned or beyond the last ROM word.
  function automatic logic rom_addr_error(input logic [31:0] addr, input int unsigned depth);
    return ((addr[1:0] & ROM_ADDR_ALIGN_MASK) != 2'b00) || (32'(addr[31:2]) >= depth);
  endfunction

endpackage

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational ROM read port between the
// fetch (IF) and load (LD) requesters, with a one-cycle registered response.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = MXLEN,
  parameter int unsigned DEPTH = ROM_COL_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [31:0]     if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_err,
  input  logic            ld_req,
  input  logic [31:0]     ld_addr,
  output logic            ld_gnt,
  output logic            ld_rvalid,
  output logic [XLEN-1:0] ld_rdata,
  output logic            ld_err,
  output logic [31:0]     rom_addr,
  input  logic [XLEN-1:0] rom_data,
  output logic [31:0]     conflict_cnt
);

  rom_port_e       last_gnt_q;
  logic            rsp_valid_q;
  rom_port_e       rsp_port_q;
  logic            rsp_err_q;
  logic [XLEN-1:0] rsp_data_q;
  logic [31:0]     conflict_q;

  logic if_elig, ld_elig, any_gnt, gnt_err;

  // Grants are held off while reset is asserted, not just until the next edge.
  assign if_elig = rst_n && if_req && !if_flush;
  assign ld_elig = rst_n && ld_req;
  assign any_gnt = if_gnt || ld_gnt;

  // Grant selection: sole eligible port wins, conflicts go opposite last_gnt.
  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (if_elig && ld_elig) begin
      if (last_gnt_q == RomPortLd) begin
        if_gnt = 1'b1;
      end else begin
        ld_gnt = 1'b1;
      end
    end else begin
      if_gnt = if_elig;
      ld_gnt = ld_elig;
    end
  end

  // ROM address mux and check of the granted address.
  always_comb begin
    rom_addr = 32'h0;
    if (if_gnt) begin
      rom_addr = if_addr;
    end else if (ld_gnt) begin
      rom_addr = ld_addr;
    end
    gnt_err = any_gnt && rom_addr_error(rom_addr, DEPTH);
  end

  // Response capture, round-robin pointer and saturating conflict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= RomPortLd;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= RomPortIf;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      conflict_q  <= 32'h0;
    end else begin
      rsp_valid_q <= any_gnt;
      rsp_port_q  <= ld_gnt ? RomPortLd : RomPortIf;
      rsp_err_q   <= gnt_err;
      rsp_data_q  <= (any_gnt && !gnt_err) ? rom_data : '0;
      if (any_gnt) begin
        last_gnt_q <= ld_gnt ? RomPortLd : RomPortIf;
      end
      if (if_req && ld_req && (conflict_q != 32'hFFFF_FFFF)) begin
        conflict_q <= conflict_q + 32'd1;
      end
    end
  end

  // Response steering; a flush in the response cycle discards the IF response.
  always_comb begin
    if_rvalid = rsp_valid_q && (rsp_port_q == RomPortIf) && !if_flush;
    ld_rvalid = rsp_valid_q && (rsp_port_q == RomPortLd);
    if_err    = if_rvalid && rsp_err_q;
    ld_err    = ld_rvalid && rsp_err_q;
    if_rdata  = if_rvalid ? rsp_data_q : '0;
    ld_rdata  = ld_rvalid ? rsp_data_q : '0;
  end

  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: inputs change on the falling edge and all
// outputs are checked mid-cycle, so each step sees the current grant and the
// response to the previous cycle's grant.
module tb_rom_arbiter;

  localparam int unsigned Xlen  = 32;
  localparam int unsigned Depth = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_req, if_flush, ld_req;
  logic [31:0]     if_addr, ld_addr;
  logic            if_gnt, if_rvalid, if_err;
  logic            ld_gnt, ld_rvalid, ld_err;
  logic [Xlen-1:0] if_rdata, ld_rdata;
  logic [31:0]     rom_addr;
  logic [Xlen-1:0] rom_data;
  logic [31:0]     conflict_cnt;
  logic [Xlen-1:0] rom_mem [Depth];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural ROM: word i holds 0xA500_0000 | i, except word 2.
  always_comb begin
    rom_data = 32'h0;
    if (rom_addr[31:6] == 26'h0) rom_data = rom_mem[rom_addr[5:2]];
  end

  rom_arbiter #(
    .XLEN  (Xlen),
    .DEPTH (Depth)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_flush     (if_flush),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_gnt       (ld_gnt),
    .ld_rvalid    (ld_rvalid),
    .ld_rdata     (ld_rdata),
    .ld_err       (ld_err),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, settle.
  task automatic step(input logic ir, input logic [31:0] ia, input logic fl,
                      input logic lr, input logic [31:0] la);
    @(negedge clk);
    if_req   = ir;
    if_addr  = ia;
    if_flush = fl;
    ld_req   = lr;
    ld_addr  = la;
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(Depth); i++) rom_mem[i] = 32'hA500_0000 | i;
    rom_mem[2] = 32'hDEAD_BEEF;

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0; ld_req = 1'b0; ld_addr = '0;

    // Reset: requests present but no grants, everything cleared.
    step(1'b1, 32'h8, 1'b0, 1'b1, 32'h4);
    step(1'b1, 32'h8, 1'b0, 1'b1, 32'h4);
    check("rst_if_gnt", 32'(if_gnt), 32'h0);
    check("rst_ld_gnt", 32'(ld_gnt), 32'h0);
    check("rst_rvalid", {30'h0, if_rvalid, ld_rvalid}, 32'h0);
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_cnt", conflict_cnt, 32'h0);
    check("rst_rdata", if_rdata | ld_rdata, 32'h0);

    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;

    // IF-only read of word 2.
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    check("if_only_gnt", {30'h0, if_gnt, ld_gnt}, 32'h2);
    check("if_only_addr", rom_addr, 32'h8);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("if_only_rvalid", 32'(if_rvalid), 32'h1);
    check("if_only_rdata", if_rdata, 32'hDEAD_BEEF);
    check("if_only_err", 32'(if_err), 32'h0);
    check("if_only_ld_rvalid", 32'(ld_rvalid), 32'h0);

    // LD misaligned, then LD just past the last word.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h6);
    check("ld_mis_gnt", 32'(ld_gnt), 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1, Depth * 4);
    check("ld_mis_err", {30'h0, ld_rvalid, ld_err}, 32'h3);
    check("ld_mis_rdata", ld_rdata, 32'h0);
    check("ld_oor_gnt", 32'(ld_gnt), 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("ld_oor_err", {30'h0, ld_rvalid, ld_err}, 32'h3);
    check("ld_oor_rdata", ld_rdata, 32'h0);
    check("ld_oor_cnt", conflict_cnt, 32'h0);

    // Four cycles of dual requests: IF, LD, IF, LD.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h10, 1'b0, 1'b1, 32'h20);
      check($sformatf("dual%0d_gnt", i), {30'h0, if_gnt, ld_gnt},
            (i % 2 == 0) ? 32'h2 : 32'h1);
      if (i > 0) begin
        check($sformatf("dual%0d_prev_rv", i), {30'h0, if_rvalid, ld_rvalid},
              (i % 2 == 1) ? 32'h2 : 32'h1);
        check($sformatf("dual%0d_prev_data", i), if_rdata | ld_rdata,
              (i % 2 == 1) ? 32'hA500_0004 : 32'hA500_0008);
      end
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("dual_last_rv", {30'h0, if_rvalid, ld_rvalid}, 32'h1);
    check("dual_last_data", ld_rdata, 32'hA500_0008);
    check("dual_cnt", conflict_cnt, 32'h4);

    // IF granted, then flushed while LD requests.
    step(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
    check("fl_if_gnt", 32'(if_gnt), 32'h1);
    step(1'b1, 32'hC, 1'b1, 1'b1, 32'h14);
    check("fl_if_rvalid", 32'(if_rvalid), 32'h0);
    check("fl_gnt", {30'h0, if_gnt, ld_gnt}, 32'h1);
    check("fl_rom_addr", rom_addr, 32'h14);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("fl_ld_rvalid", {30'h0, if_rvalid, ld_rvalid}, 32'h1);
    check("fl_ld_rdata", ld_rdata, 32'hA500_0005);
    check("fl_cnt", conflict_cnt, 32'h5);

    // Reset in the cycle after a grant drops the pending response.
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    check("mid_if_gnt", 32'(if_gnt), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    if_req = 1'b0;
    #1;
    check("mid_rst_rvalid", {30'h0, if_rvalid, ld_rvalid}, 32'h0);
    check("mid_rst_cnt", conflict_cnt, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("post_rst_rvalid", {30'h0, if_rvalid, ld_rvalid}, 32'h0);
    step(1'b1, 32'h0, 1'b0, 1'b1, 32'h4);
    check("post_rst_gnt", {30'h0, if_gnt, ld_gnt}, 32'h2);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("post_rst_rdata", if_rdata, 32'hA500_0000);
    check("post_rst_cnt", conflict_cnt, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
